// File: rtl/urv_decode_if.sv
// Fetch-to-decode and decode-to-execute signal bundle for urv_decode.
// slave = decode stage, master = surrounding pipeline (fetch/execute/regfile).
interface urv_decode_if;
  logic        f_valid_i;
  logic [31:0] f_ir_i;
  logic [31:0] f_pc_i;
  logic        f_stall_o;
  logic        d_stall_i;
  logic        d_kill_i;
  logic [4:0]  rf_rs1_o;
  logic [4:0]  rf_rs2_o;
  logic        d_valid_o;
  logic [31:0] d_pc_o;
  logic [4:0]  d_opcode_o;
  logic [2:0]  d_fun_o;
  logic        d_fun7_o;
  logic [4:0]  d_rs1_o;
  logic [4:0]  d_rs2_o;
  logic [4:0]  d_rd_o;
  logic [31:0] d_imm_o;
  logic        d_is_load_o;
  logic        d_is_store_o;
  logic        d_is_branch_o;
  logic        d_is_mul_o;
  logic        d_illegal_o;

  modport slave (
    input  f_valid_i, f_ir_i, f_pc_i, d_stall_i, d_kill_i,
    output f_stall_o, rf_rs1_o, rf_rs2_o, d_valid_o, d_pc_o, d_opcode_o,
           d_fun_o, d_fun7_o, d_rs1_o, d_rs2_o, d_rd_o, d_imm_o,
           d_is_load_o, d_is_store_o, d_is_branch_o, d_is_mul_o, d_illegal_o
  );

  modport master (
    output f_valid_i, f_ir_i, f_pc_i, d_stall_i, d_kill_i,
    input  f_stall_o, rf_rs1_o, rf_rs2_o, d_valid_o, d_pc_o, d_opcode_o,
           d_fun_o, d_fun7_o, d_rs1_o, d_rs2_o, d_rd_o, d_imm_o,
           d_is_load_o, d_is_store_o, d_is_branch_o, d_is_mul_o, d_illegal_o
  );
endinterface

// File: rtl/urv_decode.sv
// uRV decode stage: registers decoded fields and inserts one bubble on load-use.
// Optional RV32M decode enabled by defining URV_DECODE_MULDIV_EN.
module urv_decode #(
  parameter bit g_load_interlock = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  urv_decode_if.slave bus
);
  localparam logic [4:0] OPC_LOAD    = 5'b00000;
  localparam logic [4:0] OPC_MISCMEM = 5'b00011;
  localparam logic [4:0] OPC_OPIMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC   = 5'b00101;
  localparam logic [4:0] OPC_STORE   = 5'b01000;
  localparam logic [4:0] OPC_OP      = 5'b01100;
  localparam logic [4:0] OPC_LUI     = 5'b01101;
  localparam logic [4:0] OPC_BRANCH  = 5'b11000;
  localparam logic [4:0] OPC_JALR    = 5'b11001;
  localparam logic [4:0] OPC_JAL     = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM  = 5'b11100;

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_BUBBLE = 1'b1;

  logic [31:0] ir;
  logic [4:0]  opc;
  logic        quad_ok, op_m, known, use_rs1, use_rs2;
  logic [31:0] imm_d;
  logic [4:0]  rd_d;
  logic        is_load_d, is_store_d, is_branch_d, is_mul_d, illegal_d;
  logic        rs_match, hazard;

  logic [0:0]  state_q;
  logic        d_valid_q, d_fun7_q;
  logic [31:0] d_pc_q, d_imm_q;
  logic [4:0]  d_opcode_q, d_rs1_q, d_rs2_q, d_rd_q;
  logic [2:0]  d_fun_q;
  logic        d_is_load_q, d_is_store_q, d_is_branch_q, d_is_mul_q, d_illegal_q;

  assign ir      = bus.f_ir_i;
  assign opc     = ir[6:2];
  assign quad_ok = (ir[1:0] == 2'b11);
  assign op_m    = (opc == OPC_OP) && (ir[31:25] == 7'b0000001);

  always_comb begin
    imm_d   = '0;
    known   = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opc)
      OPC_LUI, OPC_AUIPC: begin
        imm_d = {ir[31:12], 12'b0};
        known = 1'b1;
      end
      OPC_JAL: begin
        imm_d = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
        known = 1'b1;
      end
      OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
        imm_d   = {{20{ir[31]}}, ir[31:20]};
        known   = 1'b1;
        use_rs1 = 1'b1;
      end
      OPC_BRANCH: begin
        imm_d   = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
        known   = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_STORE: begin
        imm_d   = {{20{ir[31]}}, ir[31:25], ir[11:7]};
        known   = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_OP: begin
        known   = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_SYSTEM, OPC_MISCMEM: known = 1'b1;
      default: known = 1'b0;
    endcase
  end

  // Class flags require a 32-bit encoding so compressed-looking words never trigger a hazard
  assign is_load_d   = quad_ok && (opc == OPC_LOAD);
  assign is_store_d  = quad_ok && (opc == OPC_STORE);
  assign is_branch_d = quad_ok && ((opc == OPC_BRANCH) || (opc == OPC_JAL) || (opc == OPC_JALR));
  assign rd_d        = ((opc == OPC_STORE) || (opc == OPC_BRANCH)) ? 5'd0 : ir[11:7];
`ifdef URV_DECODE_MULDIV_EN
  assign is_mul_d  = quad_ok && op_m;
  assign illegal_d = !quad_ok || !known;
`else
  assign is_mul_d  = 1'b0;
  assign illegal_d = !quad_ok || !known || op_m;
`endif

  assign rs_match = (use_rs1 && (ir[19:15] == d_rd_q)) || (use_rs2 && (ir[24:20] == d_rd_q));
  assign hazard   = g_load_interlock && (state_q == ST_RUN) && d_valid_q && d_is_load_q &&
                    (d_rd_q != 5'd0) && bus.f_valid_i && rs_match &&
                    !bus.d_stall_i && !bus.d_kill_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_RUN;
      d_valid_q     <= 1'b0;
      d_pc_q        <= '0;
      d_opcode_q    <= '0;
      d_fun_q       <= '0;
      d_fun7_q      <= 1'b0;
      d_rs1_q       <= '0;
      d_rs2_q       <= '0;
      d_rd_q        <= '0;
      d_imm_q       <= '0;
      d_is_load_q   <= 1'b0;
      d_is_store_q  <= 1'b0;
      d_is_branch_q <= 1'b0;
      d_is_mul_q    <= 1'b0;
      d_illegal_q   <= 1'b0;
    end else if (bus.d_kill_i) begin
      state_q   <= ST_RUN;
      d_valid_q <= 1'b0;
    end else if (!bus.d_stall_i) begin
      if (hazard) begin
        state_q   <= ST_BUBBLE;
        d_valid_q <= 1'b0;
      end else begin
        // BUBBLE always returns to RUN here and accepts the instruction fetch held
        state_q       <= ST_RUN;
        d_valid_q     <= bus.f_valid_i;
        d_pc_q        <= bus.f_pc_i;
        d_opcode_q    <= opc;
        d_fun_q       <= ir[14:12];
        d_fun7_q      <= ir[30];
        d_rs1_q       <= ir[19:15];
        d_rs2_q       <= ir[24:20];
        d_rd_q        <= rd_d;
        d_imm_q       <= imm_d;
        d_is_load_q   <= is_load_d;
        d_is_store_q  <= is_store_d;
        d_is_branch_q <= is_branch_d;
        d_is_mul_q    <= is_mul_d;
        d_illegal_q   <= illegal_d;
      end
    end
  end

  assign bus.f_stall_o     = bus.d_stall_i | hazard;
  assign bus.rf_rs1_o      = ir[19:15];
  assign bus.rf_rs2_o      = ir[24:20];
  assign bus.d_valid_o     = d_valid_q;
  assign bus.d_pc_o        = d_pc_q;
  assign bus.d_opcode_o    = d_opcode_q;
  assign bus.d_fun_o       = d_fun_q;
  assign bus.d_fun7_o      = d_fun7_q;
  assign bus.d_rs1_o       = d_rs1_q;
  assign bus.d_rs2_o       = d_rs2_q;
  assign bus.d_rd_o        = d_rd_q;
  assign bus.d_imm_o       = d_imm_q;
  assign bus.d_is_load_o   = d_is_load_q;
  assign bus.d_is_store_o  = d_is_store_q;
  assign bus.d_is_branch_o = d_is_branch_q;
  assign bus.d_is_mul_o    = d_is_mul_q;
  assign bus.d_illegal_o   = d_illegal_q;
endmodule

// File: tb/tb_urv_decode.sv
// Directed bench for urv_decode: stimulus pushes hand-decoded expectations,
// a monitor pops one each time execute accepts a valid decoded instruction.
module tb_urv_decode;
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  opc;
    logic [2:0]  fun;
    logic        fun7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        ld, st, br, mul, ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  urv_decode_if bus();

  urv_decode dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [31:0] pc, input logic [4:0] opc, input logic [2:0] fun,
                              input logic fun7, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic [31:0] imm, input logic ld,
                              input logic st, input logic br, input logic mul, input logic ill);
    exp_t e;
    e = '{pc, opc, fun, fun7, rs1, rs2, rd, imm, ld, st, br, mul, ill};
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end else
      $display("ok   %s: %h", name, act);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ir, input logic [31:0] pc);
    bus.f_valid_i = v;
    bus.f_ir_i    = ir;
    bus.f_pc_i    = pc;
  endtask

  // Scoreboard monitor: execute consumes d_* when valid and not stalled
  initial begin
    exp_t act, e;
    forever begin
      @(negedge clk);
      if (!rst && bus.d_valid_o && !bus.d_stall_i) begin
        act = mk(bus.d_pc_o, bus.d_opcode_o, bus.d_fun_o, bus.d_fun7_o, bus.d_rs1_o,
                 bus.d_rs2_o, bus.d_rd_o, bus.d_imm_o, bus.d_is_load_o, bus.d_is_store_o,
                 bus.d_is_branch_o, bus.d_is_mul_o, bus.d_illegal_o);
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_insn: got %h expected none", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            n_fail++;
            $display("FAIL decode pc=%h: got %h expected %h", e.pc, act, e);
          end else
            $display("ok   decode pc=%h: %h", e.pc, act);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic mul_ok;
`ifdef URV_DECODE_MULDIV_EN
    mul_ok = 1'b1;
`else
    mul_ok = 1'b0;
`endif
    drive(1'b0, 32'h0, 32'h0);
    bus.d_stall_i = 1'b0;
    bus.d_kill_i  = 1'b0;
    tick();
    tick();
    chk("reset_valid", {31'b0, bus.d_valid_o}, 32'd0);
    chk("reset_pc", bus.d_pc_o, 32'd0);
    chk("reset_imm", bus.d_imm_o, 32'd0);
    chk("reset_rd", {27'b0, bus.d_rd_o}, 32'd0);
    chk("reset_stall", {31'b0, bus.f_stall_o}, 32'd0);
    rst = 1'b0;

    // addi x1,x0,5
    drive(1'b1, 32'h00500093, 32'd0);
    exp_q.push_back(mk(32'd0, 5'h04, 3'd0, 1'b0, 5'd0, 5'd5, 5'd1, 32'd5, 0, 0, 0, 0, 0));
    #1 chk("rf_rs2_comb", {27'b0, bus.rf_rs2_o}, 32'd5);
    tick();
    chk("addi_valid", {31'b0, bus.d_valid_o}, 32'd1);

    // lw x2,0(x1) then add x3,x2,x2: one bubble
    drive(1'b1, 32'h0000A103, 32'd4);
    exp_q.push_back(mk(32'd4, 5'h00, 3'd2, 1'b0, 5'd1, 5'd0, 5'd2, 32'd0, 1, 0, 0, 0, 0));
    tick();
    drive(1'b1, 32'h002101B3, 32'd8);
    exp_q.push_back(mk(32'd8, 5'h0C, 3'd0, 1'b0, 5'd2, 5'd2, 5'd3, 32'd0, 0, 0, 0, 0, 0));
    #1 chk("ld_use_stall", {31'b0, bus.f_stall_o}, 32'd1);
    tick();
    chk("bubble_valid", {31'b0, bus.d_valid_o}, 32'd0);
    chk("bubble_no_restall", {31'b0, bus.f_stall_o}, 32'd0);
    tick();
    chk("add_after_bubble", {31'b0, bus.d_valid_o}, 32'd1);

    // lw x0,0(x1) then add x3,x0,x0: no hazard
    drive(1'b1, 32'h0000A003, 32'd12);
    exp_q.push_back(mk(32'd12, 5'h00, 3'd2, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0, 1, 0, 0, 0, 0));
    #1 chk("add_then_load_stall", {31'b0, bus.f_stall_o}, 32'd0);
    tick();
    drive(1'b1, 32'h000001B3, 32'd16);
    exp_q.push_back(mk(32'd16, 5'h0C, 3'd0, 1'b0, 5'd0, 5'd0, 5'd3, 32'd0, 0, 0, 0, 0, 0));
    #1 chk("x0_no_stall", {31'b0, bus.f_stall_o}, 32'd0);
    tick();
    chk("x0_no_bubble", {31'b0, bus.d_valid_o}, 32'd1);

    // addi x5,x0,-1 then 3-cycle execute stall with sw x5,8(x1) waiting
    drive(1'b1, 32'hFFF00293, 32'd20);
    exp_q.push_back(mk(32'd20, 5'h04, 3'd0, 1'b1, 5'd0, 5'd31, 5'd5, 32'hFFFFFFFF, 0, 0, 0, 0, 0));
    tick();
    bus.d_stall_i = 1'b1;
    drive(1'b1, 32'h0050A423, 32'd24);
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_fstall", {31'b0, bus.f_stall_o}, 32'd1);
      tick();
      chk("stall_hold_pc", bus.d_pc_o, 32'd20);
      chk("stall_hold_imm", bus.d_imm_o, 32'hFFFFFFFF);
    end
    bus.d_stall_i = 1'b0;
    exp_q.push_back(mk(32'd24, 5'h08, 3'd2, 1'b0, 5'd1, 5'd5, 5'd0, 32'd8, 0, 1, 0, 0, 0));
    tick();

    // lui, beq (negative), jal, mul, all-zero word
    drive(1'b1, 32'h123453B7, 32'd28);
    exp_q.push_back(mk(32'd28, 5'h0D, 3'd5, 1'b0, 5'd8, 5'd3, 5'd7, 32'h12345000, 0, 0, 0, 0, 0));
    tick();
    drive(1'b1, 32'hFE208EE3, 32'd32);
    exp_q.push_back(mk(32'd32, 5'h18, 3'd0, 1'b1, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFC, 0, 0, 1, 0, 0));
    tick();
    drive(1'b1, 32'h008000EF, 32'd36);
    exp_q.push_back(mk(32'd36, 5'h1B, 3'd0, 1'b0, 5'd0, 5'd8, 5'd1, 32'd8, 0, 0, 1, 0, 0));
    tick();
    drive(1'b1, 32'h02208033, 32'd40);
    exp_q.push_back(mk(32'd40, 5'h0C, 3'd0, 1'b0, 5'd1, 5'd2, 5'd0, 32'd0, 0, 0, 0, mul_ok, !mul_ok));
    tick();
    drive(1'b1, 32'h00000000, 32'd44);
    exp_q.push_back(mk(32'd44, 5'h00, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 0, 0, 0, 0, 1));
    tick();

    // kill with a valid incoming instruction
    drive(1'b1, 32'h00500093, 32'd48);
    bus.d_kill_i = 1'b1;
    tick();
    chk("kill_valid", {31'b0, bus.d_valid_o}, 32'd0);
    bus.d_kill_i = 1'b0;

    // kill while in BUBBLE
    drive(1'b1, 32'h0000A103, 32'd52);
    exp_q.push_back(mk(32'd52, 5'h00, 3'd2, 1'b0, 5'd1, 5'd0, 5'd2, 32'd0, 1, 0, 0, 0, 0));
    tick();
    drive(1'b1, 32'h002101B3, 32'd56);
    #1 chk("ld_use_stall2", {31'b0, bus.f_stall_o}, 32'd1);
    tick();
    bus.d_kill_i = 1'b1;
    #1 chk("bubble_kill_fstall", {31'b0, bus.f_stall_o}, 32'd0);
    tick();
    chk("bubble_kill_valid", {31'b0, bus.d_valid_o}, 32'd0);
    bus.d_kill_i = 1'b0;
    drive(1'b1, 32'h00500093, 32'd100);
    exp_q.push_back(mk(32'd100, 5'h04, 3'd0, 1'b0, 5'd0, 5'd5, 5'd1, 32'd5, 0, 0, 0, 0, 0));
    #1 chk("after_kill_run", {31'b0, bus.f_stall_o}, 32'd0);
    tick();
    chk("after_kill_valid", {31'b0, bus.d_valid_o}, 32'd1);

    // f_valid_i = 0 loads a bubble
    drive(1'b0, 32'h00500093, 32'd104);
    tick();
    chk("fvalid0_bubble", {31'b0, bus.d_valid_o}, 32'd0);

    // reset mid-operation drops the instruction in decode
    drive(1'b1, 32'h00500093, 32'd108);
    tick();
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("midreset_valid", {31'b0, bus.d_valid_o}, 32'd0);
    rst = 1'b0;
    tick();
    tick();
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
